// File: rtl/md_unit_pkg.sv
// md_unit_pkg: operation codes, FSM state encoding and op-decode helpers
// shared by the multiply/divide unit and its divider.
package md_unit_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIN  = 2'd3
  } md_state_e;

  function automatic logic op_is_mul(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

  function automatic logic op_is_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic op_is_signed(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/md_divider.sv
// md_divider: restoring radix-2 divider on unsigned magnitudes, one quotient
// bit per step; o_last flags the final step, o_valid holds once results are ready.
module md_divider #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic             i_step,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_last,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvs;
  logic [CW-1:0]    r_cnt;
  logic             r_run;
  logic             r_valid;

  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_trial;
  logic             w_fits;

  // Partial remainder stays below the divisor, so the trial difference is
  // negative exactly when its top bit is set.
  assign w_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_trial = w_shift - {1'b0, r_dvs};
  assign w_fits  = ~w_trial[WIDTH];

  assign o_last      = r_run && (r_cnt == CW'(WIDTH - 1));
  assign o_valid     = r_valid;
  assign o_quotient  = r_quo;
  assign o_remainder = r_rem;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rem   <= '0;
      r_quo   <= '0;
      r_dvs   <= '0;
      r_cnt   <= '0;
      r_run   <= 1'b0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_rem   <= '0;
      r_quo   <= i_dividend;
      r_dvs   <= i_divisor;
      r_cnt   <= '0;
      r_run   <= 1'b1;
      r_valid <= 1'b0;
    end else if (i_step && r_run) begin
      r_rem <= w_fits ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
      r_quo <= {r_quo[WIDTH-2:0], w_fits};
      r_cnt <= r_cnt + 1'b1;
      if (o_last) begin
        r_run   <= 1'b0;
        r_valid <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit owning the HI/LO registers.
// Define MD_FAST_MUL_EN to use a single-cycle multiplier instead of shift-add.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic             dz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  md_state_e          r_state;
  md_state_e          w_state_nxt;

  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;
  logic               r_dz;
  logic               r_is_div;
  logic               r_neg_q;
  logic               r_neg_r;
  logic [2*WIDTH-1:0] r_acc;

`ifndef MD_FAST_MUL_EN
  localparam int CW = $clog2(WIDTH);
  logic [WIDTH-1:0]   r_mcand;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH:0]     w_acc_sum;
`endif

  logic               w_accept;
  logic               w_a_neg;
  logic               w_b_neg;
  logic               w_b_zero;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic               w_div_load;
  logic               w_div_step;
  logic               w_div_last;
  logic               w_div_valid;
  logic               w_fin;
  logic [WIDTH-1:0]   w_quo_mag;
  logic [WIDTH-1:0]   w_rem_mag;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic [2*WIDTH-1:0] w_prod;

  assign w_accept = (r_state == ST_IDLE) && start && !cancel;
  assign w_a_neg  = op_is_signed(op) && a[WIDTH-1];
  assign w_b_neg  = op_is_signed(op) && b[WIDTH-1];
  assign w_b_zero = (b == '0);
  // The most-negative value negates to itself, which read unsigned is its magnitude.
  assign w_mag_a  = w_a_neg ? -a : a;
  assign w_mag_b  = w_b_neg ? -b : b;

  md_divider #(.WIDTH(WIDTH)) u_div (
    .i_clk       (CLK),
    .i_rst       (RST),
    .i_load      (w_div_load),
    .i_step      (w_div_step),
    .i_dividend  (w_mag_a),
    .i_divisor   (w_mag_b),
    .o_last      (w_div_last),
    .o_valid     (w_div_valid),
    .o_quotient  (w_quo_mag),
    .o_remainder (w_rem_mag)
  );

  always_ff @(posedge CLK) begin
    if (RST) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    w_state_nxt = r_state;
    w_div_load  = 1'b0;
    w_div_step  = 1'b0;
    w_fin       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (op_is_mul(op)) begin
`ifdef MD_FAST_MUL_EN
            w_state_nxt = ST_FIN;
`else
            w_state_nxt = ST_MUL;
`endif
          end else if (op_is_div(op)) begin
            if (w_b_zero) begin
              w_state_nxt = ST_FIN;
            end else begin
              w_state_nxt = ST_DIV;
              w_div_load  = 1'b1;
            end
          end
        end
      end
      ST_MUL: begin
`ifdef MD_FAST_MUL_EN
        w_state_nxt = ST_FIN;
`else
        if (r_cnt == CW'(WIDTH - 1)) w_state_nxt = ST_FIN;
`endif
      end
      ST_DIV: begin
        w_div_step = 1'b1;
        if (w_div_last) w_state_nxt = ST_FIN;
      end
      ST_FIN: begin
        w_fin       = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (cancel && (r_state != ST_IDLE)) begin
      w_state_nxt = ST_IDLE;
      w_fin       = 1'b0;
    end
  end

`ifndef MD_FAST_MUL_EN
  // Low half of the accumulator starts as the multiplier and is consumed LSB first.
  assign w_acc_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_mcand} : '0);
`endif

  assign w_prod = r_neg_q ? -r_acc : r_acc;
  assign w_quo  = r_neg_q ? -w_quo_mag : w_quo_mag;
  assign w_rem  = r_neg_r ? -w_rem_mag : w_rem_mag;

  always_ff @(posedge CLK) begin
    if (RST) begin
      // NOTE: working registers are reset too so no X ever reaches HI/LO.
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
      r_dz     <= 1'b0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_acc    <= '0;
`ifndef MD_FAST_MUL_EN
      r_mcand  <= '0;
      r_cnt    <= '0;
`endif
    end else begin
      // NOTE: non-blocking throughout, so each register sees pre-edge values regardless of order.
      r_done <= w_fin;
      if (w_accept) begin
        case (op)
          MD_MTHI: r_hi <= a;
          MD_MTLO: r_lo <= a;
          MD_MULT, MD_MULTU: begin
            r_dz     <= 1'b0;
            r_is_div <= 1'b0;
            r_neg_q  <= w_a_neg ^ w_b_neg;
`ifdef MD_FAST_MUL_EN
            r_acc    <= (2*WIDTH)'(w_mag_a) * (2*WIDTH)'(w_mag_b);
`else
            r_acc    <= {{WIDTH{1'b0}}, w_mag_b};
            r_mcand  <= w_mag_a;
            r_cnt    <= '0;
`endif
          end
          MD_DIV, MD_DIVU: begin
            r_dz     <= w_b_zero;
            r_is_div <= 1'b1;
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
          end
          default: ;
        endcase
      end
`ifndef MD_FAST_MUL_EN
      if (r_state == ST_MUL) begin
        r_acc <= {w_acc_sum, r_acc[WIDTH-1:1]};
        r_cnt <= r_cnt + 1'b1;
      end
`endif
      if (w_fin) begin
        if (!r_is_div) begin
          {r_hi, r_lo} <= w_prod;
        end else if (!r_dz && w_div_valid) begin
          r_hi <= w_rem;
          r_lo <= w_quo;
        end
      end
    end
  end

  assign busy = (r_state != ST_IDLE);
  assign done = r_done;
  assign dz   = r_dz;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: randomized bench for md_unit (WIDTH=32 and WIDTH=8 instances),
// checked against an arithmetic reference model of HI/LO/dz and latency.
`timescale 1ns/1ps
module tb_md_unit;
  import md_unit_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         cancel;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic         dz;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  logic         s8_start;
  logic [2:0]   s8_op;
  logic [7:0]   s8_a;
  logic [7:0]   s8_b;
  logic         s8_busy;
  logic         s8_done;
  logic         s8_dz;
  logic [7:0]   s8_hi;
  logic [7:0]   s8_lo;

  int n_checks = 0;
  int n_errors = 0;

  // Committed model state, plus the pending result of the op just issued.
  logic [63:0] m_hi, m_lo, p_hi, p_lo, m8_hi, m8_lo;
  logic        m_dz, p_dz, m8_dz;
  int          p_lat;

  always #5 clk = ~clk;

  md_unit #(.WIDTH(W)) u_dut (
    .CLK(clk), .RST(rst), .start(start), .op(op), .a(a), .b(b), .cancel(cancel),
    .busy(busy), .done(done), .dz(dz), .hi(hi), .lo(lo)
  );

  md_unit #(.WIDTH(8)) u_dut8 (
    .CLK(clk), .RST(rst), .start(s8_start), .op(s8_op), .a(s8_a), .b(s8_b), .cancel(1'b0),
    .busy(s8_busy), .done(s8_done), .dz(s8_dz), .hi(s8_hi), .lo(s8_lo)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int mul_lat(input int w);
`ifdef MD_FAST_MUL_EN
    return (w > 0) ? 1 : 1;
`else
    return w + 1;
`endif
  endfunction

  // Architectural result of one request: new HI/LO/dz and cycles to done
  // (0 = immediate MTHI/MTLO, -1 = ignored op code).
  function automatic void model(input int w, input logic [2:0] o,
                                input logic [63:0] aa, input logic [63:0] bb,
                                input logic [63:0] ohi, input logic [63:0] olo, input logic odz,
                                output logic [63:0] nhi, output logic [63:0] nlo,
                                output logic ndz, output int lat);
    logic [63:0]  mask, ua, ub;
    longint       sa, sb, sp, q, r;
    logic [127:0] p;
    mask = (64'd1 << w) - 64'd1;
    ua   = aa & mask;
    ub   = bb & mask;
    sa   = $signed(ua << (64 - w)) >>> (64 - w);
    sb   = $signed(ub << (64 - w)) >>> (64 - w);
    nhi  = ohi;
    nlo  = olo;
    ndz  = odz;
    lat  = 0;
    case (o)
      MD_MULT, MD_MULTU: begin
        if (o == MD_MULT) begin
          sp = sa * sb;
          p  = {{64{sp[63]}}, sp};
        end else begin
          p = {64'd0, ua} * {64'd0, ub};
        end
        nlo = p[63:0] & mask;
        nhi = 64'(p >> w) & mask;
        ndz = 1'b0;
        lat = mul_lat(w);
      end
      MD_DIV, MD_DIVU: begin
        ndz = (ub == 64'd0);
        if (ub == 64'd0) begin
          lat = 1;
        end else begin
          lat = w + 1;
          if (o == MD_DIV) begin
            q = sa / sb;
            r = sa % sb;
          end else begin
            q = longint'(ua / ub);
            r = longint'(ua % ub);
          end
          nlo = 64'(q) & mask;
          nhi = 64'(r) & mask;
        end
      end
      MD_MTHI: nhi = ua;
      MD_MTLO: nlo = ua;
      default: lat = -1;
    endcase
  endfunction

  function automatic logic [31:0] rnd_opnd(input int w);
    logic [31:0] mask;
    mask = 32'hFFFF_FFFF >> (32 - w);
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return mask;
      3:       return 32'd1 << (w - 1);
      4:       return 32'($urandom_range(0, 15));
      default: return $urandom & mask;
    endcase
  endfunction

  // Called at a falling edge; returns at the falling edge after the accept edge.
  task automatic start_op(input logic [2:0] o, input logic [31:0] aa, input logic [31:0] bb);
    model(W, o, {32'd0, aa}, {32'd0, bb}, m_hi, m_lo, m_dz, p_hi, p_lo, p_dz, p_lat);
    start = 1'b1;
    op    = o;
    a     = aa;
    b     = bb;
    @(negedge clk);
    start = 1'b0;
    op    = 3'($urandom);
    a     = $urandom;
    b     = $urandom;
  endtask

  // Waits for done (bounded), checks latency and results; ends on the done cycle.
  task automatic finish_op(input string tag, input int intrude);
    int n;
    if (p_lat <= 0) begin
      check({tag, ":busy"}, 64'(busy), 64'd0);
      check({tag, ":done"}, 64'(done), 64'd0);
    end else begin
      check({tag, ":busy"}, 64'(busy), 64'd1);
      n = 0;
      while (!done && n < 100) begin
        if (n == intrude) begin
          start = 1'b1;
          op    = 3'($urandom_range(0, 5));
          a     = $urandom;
          b     = $urandom;
        end
        @(negedge clk);
        n++;
        start = 1'b0;
      end
      check({tag, ":latency"}, 64'(n), 64'(p_lat));
      check({tag, ":busy_end"}, 64'(busy), 64'd0);
    end
    check({tag, ":hi"}, 64'(hi), p_hi);
    check({tag, ":lo"}, 64'(lo), p_lo);
    check({tag, ":dz"}, 64'(dz), 64'(p_dz));
    m_hi = p_hi;
    m_lo = p_lo;
    m_dz = p_dz;
  endtask

  task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] aa,
                       input logic [31:0] bb, input int intrude);
    int lat;
    start_op(o, aa, bb);
    lat = p_lat;
    finish_op(tag, intrude);
    if (lat > 0) begin
      @(negedge clk);
      check({tag, ":pulse"}, 64'(done), 64'd0);
    end
  endtask

  task automatic op8(input string tag, input logic [2:0] o, input logic [7:0] aa, input logic [7:0] bb);
    logic [63:0] nh, nl;
    logic        nd;
    int          lat, n;
    model(8, o, {56'd0, aa}, {56'd0, bb}, m8_hi, m8_lo, m8_dz, nh, nl, nd, lat);
    s8_start = 1'b1;
    s8_op    = o;
    s8_a     = aa;
    s8_b     = bb;
    @(negedge clk);
    s8_start = 1'b0;
    if (lat > 0) begin
      n = 0;
      while (!s8_done && n < 100) begin
        @(negedge clk);
        n++;
      end
      check({tag, ":latency"}, 64'(n), 64'(lat));
    end
    check({tag, ":hi"}, 64'(s8_hi), nh);
    check({tag, ":lo"}, 64'(s8_lo), nl);
    check({tag, ":dz"}, 64'(s8_dz), 64'(nd));
    m8_hi = nh;
    m8_lo = nl;
    m8_dz = nd;
    @(negedge clk);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    rst = 1'b1; start = 1'b0; cancel = 1'b0; op = '0; a = '0; b = '0;
    s8_start = 1'b0; s8_op = '0; s8_a = '0; s8_b = '0;
    m_hi = '0; m_lo = '0; m_dz = 1'b0; m8_hi = '0; m8_lo = '0; m8_dz = 1'b0;
    repeat (3) @(negedge clk);
    check("reset:busy", 64'(busy), 64'd0);
    check("reset:done", 64'(done), 64'd0);
    check("reset:dz",   64'(dz),   64'd0);
    check("reset:hi",   64'(hi),   64'd0);
    check("reset:lo",   64'(lo),   64'd0);
    rst = 1'b0;
    @(negedge clk);

    do_op("mult_m2x3",  MD_MULT, 32'hFFFF_FFFE, 32'd3, -1);
    do_op("divu_100_7", MD_DIVU, 32'd100, 32'd7, -1);
    do_op("div_m7_2",   MD_DIV,  32'hFFFF_FFF9, 32'd2, -1);
    do_op("div_ovf",    MD_DIV,  32'h8000_0000, 32'hFFFF_FFFF, -1);
    do_op("mthi",       MD_MTHI, 32'h1234_5678, 32'd0, -1);
    do_op("div_by0",    MD_DIV,  32'd5, 32'd0, -1);
    do_op("mtlo_dz",    MD_MTLO, 32'hCAFE_F00D, 32'd0, -1);
    do_op("undef6",     3'd6,    32'h1111_1111, 32'h2222_2222, -1);
    do_op("undef7",     3'd7,    32'h3333_3333, 32'h4444_4444, -1);

    // cancel together with start in IDLE: nothing may be accepted
    cancel = 1'b1; start = 1'b1; op = MD_MTHI; a = 32'hDEAD_BEEF;
    @(negedge clk);
    cancel = 1'b0; start = 1'b0;
    check("cs_mthi:hi", 64'(hi), m_hi);
    cancel = 1'b1; start = 1'b1; op = MD_MULT; a = 32'd7; b = 32'd9;
    @(negedge clk);
    cancel = 1'b0; start = 1'b0;
    check("cs_mult:busy", 64'(busy), 64'd0);
    check("cs_mult:dz",   64'(dz),   64'(m_dz));

    do_op("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5);

    // back-to-back: the second request is issued in the done cycle of the first
    start_op(MD_MULT, $urandom, $urandom);
    finish_op("b2b_first", -1);
    start_op(MD_DIVU, $urandom, 32'($urandom_range(1, 1000)));
    finish_op("b2b_second", -1);
    @(negedge clk);
    check("b2b:pulse", 64'(done), 64'd0);

    // cancel an in-flight DIVU: HI/LO keep prior values, no done
    start_op(MD_DIVU, 32'd1000, 32'd3);
    repeat (10) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check("cancel:busy", 64'(busy), 64'd0);
    seen = 1'b0;
    repeat (40) begin
      if (done) seen = 1'b1;
      @(negedge clk);
    end
    check("cancel:no_done", 64'(seen), 64'd0);
    check("cancel:hi", 64'(hi), m_hi);
    check("cancel:lo", 64'(lo), m_lo);
    m_dz = p_dz;
    check("cancel:dz", 64'(dz), 64'(m_dz));

    // reset in the middle of a multiply
    do_op("pre_rst_mthi", MD_MTHI, 32'hA5A5_5A5A, 32'd0, -1);
    do_op("pre_rst_div0", MD_DIVU, 32'd9, 32'd0, -1);
    start_op(MD_MULT, 32'h0001_2345, 32'h0000_6789);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid:busy", 64'(busy), 64'd0);
    check("rst_mid:done", 64'(done), 64'd0);
    check("rst_mid:dz",   64'(dz),   64'd0);
    check("rst_mid:hi",   64'(hi),   64'd0);
    check("rst_mid:lo",   64'(lo),   64'd0);
    rst = 1'b0;
    m_hi = '0; m_lo = '0; m_dz = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 60; i++) begin
      do_op($sformatf("rnd%0d", i), 3'($urandom_range(0, 7)), rnd_opnd(W), rnd_opnd(W), -1);
    end

    op8("w8_mult_80x80", MD_MULT, 8'h80, 8'h80);
    op8("w8_div_ovf",    MD_DIV,  8'h80, 8'hFF);
    for (int i = 0; i < 20; i++) begin
      op8($sformatf("w8_rnd%0d", i), 3'($urandom_range(0, 5)), 8'(rnd_opnd(8)), 8'(rnd_opnd(8)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
